// File: rtl/audio_timing_pkg.sv
// Shared timing constants, state encoding and helpers for the audio output scheduler.
package audio_timing_pkg;

  localparam int unsigned SAMPLE_PERIOD  = 2272;
  localparam int unsigned SUB_PERIOD     = 142;
  localparam int unsigned UPSAMPLE_RATIO = 16;
  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned PHASE_W        = $clog2(UPSAMPLE_RATIO);
  localparam int unsigned COUNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sample_scheduler_if.sv
// Source-stream / upsampler-side bus of the sample scheduler.
interface sample_scheduler_if;
  import audio_timing_pkg::*;

  // Handshake: src_data transfers on a rising clk edge where src_valid && src_ready;
  // the source keeps src_valid and src_data stable until that edge.
  logic                enable;
  logic [SAMPLE_W-1:0] src_data;      // two's-complement sample
  logic                src_valid;
  logic                src_ready;
  logic [SAMPLE_W-1:0] up_sample;
  logic                up_sample_valid;
  logic [PHASE_W-1:0]  up_phase;
  logic                phase_strobe;
  logic [COUNT_W-1:0]  underrun_count;
  logic                clear_underrun;
  sched_state_t        dbg_state;

  modport master (
    output enable, src_data, src_valid, clear_underrun,
    input  src_ready, up_sample, up_sample_valid, up_phase, phase_strobe,
           underrun_count, dbg_state
  );

  modport slave (
    input  enable, src_data, src_valid, clear_underrun,
    output src_ready, up_sample, up_sample_valid, up_phase, phase_strobe,
           underrun_count, dbg_state
  );

endinterface

// File: rtl/sample_scheduler_period_counter.sv
// Wrapping sample-period counter with tick, upsample phase and phase strobe.
module period_counter
  import audio_timing_pkg::*;
#(
  parameter int unsigned PERIOD = SAMPLE_PERIOD,
  parameter int unsigned SUB    = SUB_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               active,
  output logic               tick,
  output logic [PHASE_W-1:0] up_phase,
  output logic               phase_strobe
);

  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [PHASE_W-1:0] ph_q, ph_d;
  logic [PHASE_W-1:0] up_phase_q, up_phase_d;
  logic               strobe_q, strobe_d;

  // Counter sits at zero whenever inactive so the first active cycle is a tick.
  always_comb begin
    cnt_d = '0;
    sub_d = '0;
    ph_d  = '0;
    if (active && (cnt_q != CNT_W'(PERIOD - 1))) begin
      cnt_d = cnt_q + 1'b1;
      if (sub_q == SUB_W'(SUB - 1)) begin
        sub_d = '0;
        ph_d  = ph_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
        ph_d  = ph_q;
      end
    end
  end

  always_comb begin
    up_phase_d = active ? ph_q : '0;
    strobe_d   = active && (sub_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sub_q      <= '0;
      ph_q       <= '0;
      up_phase_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      ph_q       <= ph_d;
      up_phase_q <= up_phase_d;
      strobe_q   <= strobe_d;
    end
  end

  assign tick         = active && (cnt_q == '0);
  assign up_phase     = up_phase_q;
  assign phase_strobe = strobe_q;

endmodule

// File: rtl/sample_scheduler.sv
// Paces a voice-mixer sample stream into one upsampler sample per period through
// a one-entry buffer, with bypass on tick and a saturating underrun counter.
module sample_scheduler #(
  parameter int unsigned SAMPLE_PERIOD = audio_timing_pkg::SAMPLE_PERIOD,
  parameter int unsigned SUB_PERIOD    = audio_timing_pkg::SUB_PERIOD
) (
  input logic               clk,
  input logic               rst_n,
  sample_scheduler_if.slave bus
);
  import audio_timing_pkg::*;

  sched_state_t        state_q, state_d;
  logic [SAMPLE_W-1:0] buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic [SAMPLE_W-1:0] up_sample_q, up_sample_d;
  logic                valid_q, valid_d;
  logic [COUNT_W-1:0]  underrun_q, underrun_d;
  logic                src_ready, hs, active, tick, underrun;
  logic [PHASE_W-1:0]  up_phase;
  logic                phase_strobe;

  // Dropping enable silences the period logic in the same cycle, so no pulse leaks into IDLE.
  assign active = (state_q == ST_RUN) && bus.enable;
  assign hs     = bus.src_valid && src_ready;

  period_counter #(
    .PERIOD(SAMPLE_PERIOD),
    .SUB   (SUB_PERIOD)
  ) u_period_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (active),
    .tick        (tick),
    .up_phase    (up_phase),
    .phase_strobe(phase_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: if (hs) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    src_ready = 1'b0;
    if (bus.enable) begin
      unique case (state_q)
        ST_FILL: src_ready = 1'b1;
        ST_RUN:  src_ready = !buf_full_q || tick;
        default: src_ready = 1'b0;
      endcase
    end
  end

  // Buffer / emit path: on a tick the buffered sample leaves as a new one may enter.
  always_comb begin
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    up_sample_d = up_sample_q;
    valid_d     = 1'b0;
    underrun    = 1'b0;
    if (!bus.enable || (state_q == ST_IDLE)) begin
      buf_full_d = 1'b0;
    end else if (state_q == ST_FILL) begin
      if (hs) begin
        buf_d      = bus.src_data;
        buf_full_d = 1'b1;
      end
    end else if (tick) begin
      valid_d = 1'b1;
      if (buf_full_q) begin
        up_sample_d = buf_q;
        buf_full_d  = hs;
        if (hs) buf_d = bus.src_data;
      end else if (hs) begin
        up_sample_d = bus.src_data;
      end else begin
        underrun = 1'b1;
      end
    end else if (hs) begin
      buf_d      = bus.src_data;
      buf_full_d = 1'b1;
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (underrun)                underrun_d = bus.clear_underrun ? COUNT_W'(1) : sat_inc(underrun_q);
    else if (bus.clear_underrun) underrun_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      up_sample_q <= '0;
      valid_q     <= 1'b0;
      underrun_q  <= '0;
    end else begin
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      up_sample_q <= up_sample_d;
      valid_q     <= valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.src_ready       = src_ready;
  assign bus.up_sample       = up_sample_q;
  assign bus.up_sample_valid = valid_q;
  assign bus.up_phase        = up_phase;
  assign bus.phase_strobe    = phase_strobe;
  assign bus.underrun_count  = underrun_q;
  assign bus.dbg_state       = state_q;

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 2272: clk cycles between output samples.
REQ-002 Parameter SUB_PERIOD, default 142: clk cycles per upsample phase; SAMPLE_PERIOD SHALL equal 16*SUB_PERIOD.
REQ-003 clk  in  1  single system clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 enable  in  1  run request; low forces IDLE.
REQ-006 src_data  in  16  signed sample from voice mixer.
REQ-007 src_valid  in  1  src_data valid.
REQ-008 src_ready  out  1  scheduler accepts src_data this cycle.
REQ-009 up_sample  out  16  sample to upsampler; held between pulses.
REQ-010 up_sample_valid  out  1  single-cycle pulse, once per SAMPLE_PERIOD in RUN.
REQ-011 up_phase  out  4  current upsample phase, 0..15.
REQ-012 phase_strobe  out  1  single-cycle pulse at each phase start.
REQ-013 underrun_count  out  16  saturating count of ticks with no fresh sample.
REQ-014 clear_underrun  in  1  synchronous clear of underrun_count.

Function
REQ-015 States: IDLE, FILL, RUN; a handshake occurs when src_valid && src_ready.
REQ-016 IDLE: src_ready=0, one-entry buffer empty, counters 0, outputs held; enable=1 -> FILL next cycle.
REQ-017 FILL: src_ready=1; the first handshake fills the buffer; buffer full -> RUN next cycle with period counter 0.
REQ-018 In any state, enable=0 -> IDLE next cycle; the buffer is flushed and up_sample holds.
REQ-019 RUN: period counter counts 0..SAMPLE_PERIOD-1 and wraps; tick = (counter==0).
REQ-020 On tick with buffer full: up_sample <= buffer, up_sample_valid=1 next cycle, buffer emptied.
REQ-021 On tick with buffer empty and a handshake in the same cycle: bypass, src_data goes directly to up_sample and the buffer stays empty.
REQ-022 On tick with buffer empty and no handshake: underrun. up_sample holds its last value, up_sample_valid still pulses, and underrun_count increments.
REQ-023 In RUN, src_ready = buffer empty OR tick; on a handshake with a full buffer at tick, the buffer takes the new sample as the old one is emitted.
REQ-024 Latency: a sample accepted into an empty buffer appears on up_sample one cycle after the next tick.
REQ-025 up_phase = counter / SUB_PERIOD, registered alongside up_sample_valid; phase_strobe pulses when counter mod SUB_PERIOD == 0, including phase 0.
REQ-026 underrun_count saturates at 16'hFFFF; when clear_underrun and an underrun occur in the same cycle, the result is 1.
REQ-027 up_sample_valid and phase_strobe SHALL NOT assert outside RUN.

Reset
REQ-028 rst_n low: state=IDLE; src_ready=0; up_sample=0; up_sample_valid=0; up_phase=0; phase_strobe=0; underrun_count=0; buffer empty; counter=0.
REQ-029 Reset mid-RUN takes effect immediately, without waiting for a clock edge; after release the block restarts from IDLE.

Structure
REQ-030 The shared package audio_timing_pkg SHALL hold SAMPLE_PERIOD, SUB_PERIOD, UPSAMPLE_RATIO=16 and the state enum sched_state_t.
REQ-031 One sub-module, period_counter, SHALL provide the wrapping counter, tick, phase and phase_strobe; the FSM, buffer and underrun logic stay in the top.
REQ-032 Total RTL SHALL be at most 400 lines and contain no RAM.

Verification
REQ-033 Startup: enable=1, src_valid=1 with data 16'h1234 -> FILL accepts it; up_sample=16'h1234 with up_sample_valid pulsed 2 cycles after acceptance; next pulse 2272 cycles later.
REQ-034 Steady stream: source offers a new value each time src_ready is high, for 10 periods -> 10 pulses spaced 2272 cycles apart, data in order, underrun_count=0.
REQ-035 Starvation: source stops after the 3rd sample (16'h0003) -> periods 4-6 pulse with up_sample=16'h0003 and underrun_count=3; clear_underrun -> 0.
REQ-036 Phase: over one period -> 16 phase_strobe pulses, 142 cycles apart, up_phase 0..15 then wrap to 0 on the tick.
REQ-037 Bypass: buffer empty and a handshake with 16'h8000 exactly on the tick cycle -> up_sample=16'h8000 next cycle, no underrun.
REQ-038 rst_n low mid-period (counter=1000) and enable=0 mid-period -> all outputs return to reset values and no pulse occurs until FILL completes again.
